// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_pkg
// Shared constants for the multicycle MIPS-style controller: state codes,
// the opcodes the controller decodes, the alu_op codes shared with the ALU
// decoder, and the datapath select encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

endpackage

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Groups the controller's datapath-facing signals.
//   opcode, zero             : datapath -> controller
//   enables, selects, state  : controller -> datapath
// Modports: slave = controller side, master = datapath side.
// -----------------------------------------------------------------------------
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       mem_write;
    logic       reg_write;
    logic       pc_en;
    logic       iord;
    logic       alu_src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [3:0] state;

    modport slave (
        input  opcode, zero,
        output ir_write, pc_write, branch, mem_write, reg_write, pc_en,
        output iord, alu_src_a, reg_dst, mem_to_reg,
        output alu_src_b, alu_op, pc_src, state
    );

    modport master (
        output opcode, zero,
        input  ir_write, pc_write, branch, mem_write, reg_write, pc_en,
        input  iord, alu_src_a, reg_dst, mem_to_reg,
        input  alu_src_b, alu_op, pc_src, state
    );
endinterface

// File: rtl/multicycle_control_outputs.sv
// -----------------------------------------------------------------------------
// ControlOutputs
// Moore decode of the controller state into datapath enables and selects.
// Ports: state_i (current state), zero_i (ALU zero flag, only feeds pc_en_o),
//        rst_n_i (gates every write enable low while reset is held),
//        *_o enables and mux selects.
// Optional feature: JUMP_EN macro enables the JUMP state decode.
// -----------------------------------------------------------------------------
module ControlOutputs
    import multicycle_control_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       zero_i,
    input  logic       rst_n_i,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       branch_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       pc_en_o,
    output logic       iord_o,
    output logic       alu_src_a_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_src_o
);

    logic ir_write_s, pc_write_s, branch_s, mem_write_s, reg_write_s;

    // State-to-output table; anything not set for a state stays 0.
    always_comb begin
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        iord_o       = 1'b0;
        alu_src_a_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_b_o  = SRC_B_REG;
        alu_op_o     = ALU_OP_ADD;
        pc_src_o     = PC_SRC_ALU;
        case (state_i)
            S_FETCH: begin
                ir_write_s  = 1'b1;
                pc_write_s  = 1'b1;
                alu_src_b_o = SRC_B_FOUR;
            end
            S_DECODE:  alu_src_b_o = SRC_B_IMM_SH;
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
            end
            S_MEMRD:   iord_o = 1'b1;
            S_MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write_s  = 1'b1;
            end
            S_MEMWR: begin
                iord_o      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst_o   = 1'b1;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_OP_SUB;
                pc_src_o    = PC_SRC_ALUOUT;
                branch_s    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
            end
            S_ADDIWB:  reg_write_s = 1'b1;
`ifdef JUMP_EN
            S_JUMP: begin
                pc_src_o   = PC_SRC_JUMP;
                pc_write_s = 1'b1;
            end
`endif
            default: begin
                ir_write_s = 1'b0;
            end
        endcase
    end

    // Reset forces state to FETCH, whose enables are active; mask them so
    // nothing writes while rst_n is held low.
    assign ir_write_o  = ir_write_s  & rst_n_i;
    assign pc_write_o  = pc_write_s  & rst_n_i;
    assign branch_o    = branch_s    & rst_n_i;
    assign mem_write_o = mem_write_s & rst_n_i;
    assign reg_write_o = reg_write_s & rst_n_i;
    assign pc_en_o     = (pc_write_s | (branch_s & zero_i)) & rst_n_i;

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore FSM controller for a multicycle MIPS-style datapath.
// Ports: clk (rising edge), rst_n (async active-low, forces FETCH),
//        bus (multicycle_control_if.slave: opcode/zero in, controls out).
// Optional feature: JUMP_EN macro adds the j instruction / JUMP state;
// without it j decodes as illegal and code 11 returns to FETCH.
// -----------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.slave  bus
);

    state_e state_q, state_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; opcode is held stable in the IR from DECODE onward.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
`ifdef JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    assign bus.state = state_q;

    ControlOutputs u_outputs (
        .state_i      (state_q),
        .zero_i       (bus.zero),
        .rst_n_i      (rst_n),
        .ir_write_o   (bus.ir_write),
        .pc_write_o   (bus.pc_write),
        .branch_o     (bus.branch),
        .mem_write_o  (bus.mem_write),
        .reg_write_o  (bus.reg_write),
        .pc_en_o      (bus.pc_en),
        .iord_o       (bus.iord),
        .alu_src_a_o  (bus.alu_src_a),
        .reg_dst_o    (bus.reg_dst),
        .mem_to_reg_o (bus.mem_to_reg),
        .alu_src_b_o  (bus.alu_src_b),
        .alu_op_o     (bus.alu_op),
        .pc_src_o     (bus.pc_src)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Scoreboard bench: each instruction pushes its expected per-cycle output
// vectors, and the test task pops and compares them one clock at a time.
// Vector layout: {state, ir_write, pc_write, pc_en, branch, mem_write,
//                 reg_write, iord, alu_src_a, reg_dst, mem_to_reg,
//                 alu_src_b, alu_op, pc_src}
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;
    logic [19:0] exp_q[$];

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference table of expected outputs for a state.
    function automatic logic [19:0] model(input logic [3:0] st, input logic z, input logic rn);
        logic ir, pw, pe, br, mw, rw, io, sa, rd, mr;
        logic [1:0] sb, ao, ps;
        {ir, pw, pe, br, mw, rw, io, sa, rd, mr} = 10'b0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin ir = 1'b1; pw = 1'b1; sb = 2'b01; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  io = 1'b1;
            4'd4:  begin mr = 1'b1; rw = 1'b1; end
            4'd5:  begin io = 1'b1; mw = 1'b1; end
            4'd6:  begin sa = 1'b1; ao = 2'b10; end
            4'd7:  begin rd = 1'b1; rw = 1'b1; end
            4'd8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
            4'd9:  begin sa = 1'b1; sb = 2'b10; end
            4'd10: rw = 1'b1;
`ifdef JUMP_EN
            4'd11: begin ps = 2'b10; pw = 1'b1; end
`endif
            default: ir = 1'b0;
        endcase
        pe = pw | (br & z);
        ir = ir & rn; pw = pw & rn; pe = pe & rn;
        br = br & rn; mw = mw & rn; rw = rw & rn;
        return {st, ir, pw, pe, br, mw, rw, io, sa, rd, mr, sb, ao, ps};
    endfunction

    function automatic logic [19:0] act_vec();
        return {bus.state, bus.ir_write, bus.pc_write, bus.pc_en, bus.branch,
                bus.mem_write, bus.reg_write, bus.iord, bus.alu_src_a,
                bus.reg_dst, bus.mem_to_reg, bus.alu_src_b, bus.alu_op, bus.pc_src};
    endfunction

    // Drive an instruction and push the expected vector of every state it
    // visits, FETCH included, up to (not including) the next FETCH.
    task automatic push_instr(input logic [5:0] op, input logic z);
        logic [3:0] seq[$];
        bus.opcode = op;
        bus.zero   = z;
        case (op)
            6'b100011: seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            6'b101011: seq = '{4'd0, 4'd1, 4'd2, 4'd5};
            6'b000000: seq = '{4'd0, 4'd1, 4'd6, 4'd7};
            6'b001000: seq = '{4'd0, 4'd1, 4'd9, 4'd10};
            6'b000100: seq = '{4'd0, 4'd1, 4'd8};
`ifdef JUMP_EN
            6'b000010: seq = '{4'd0, 4'd1, 4'd11};
`endif
            default:   seq = '{4'd0, 4'd1};
        endcase
        foreach (seq[i]) exp_q.push_back(model(seq[i], z, 1'b1));
    endtask

    task automatic test_reset();
        logic [19:0] act;
        logic [19:0] exp;
        rst_n = 1'b0; bus.opcode = 6'b000000; bus.zero = 1'b1;
        #1;
        act = act_vec(); exp = model(4'd0, 1'b1, 1'b0); vectors++;
        if (act !== exp) begin errors++; $display("FAIL reset_hold got=%b want=%b", act, exp); end
        @(posedge clk); #1;
        act = act_vec(); vectors++;
        if (act !== exp) begin errors++; $display("FAIL reset_edge got=%b want=%b", act, exp); end
        @(negedge clk); rst_n = 1'b1; #1;
        act = act_vec(); exp = model(4'd0, 1'b1, 1'b1); vectors++;
        if (act !== exp) begin errors++; $display("FAIL reset_release got=%b want=%b", act, exp); end
    endtask

    task automatic test_instr(input string name, input logic [5:0] op, input logic z);
        logic [19:0] act;
        logic [19:0] exp;
        push_instr(op, z);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front(); act = act_vec(); vectors++;
            if (act !== exp) begin errors++; $display("FAIL %s got=%b want=%b", name, act, exp); end
            @(posedge clk); #1;
        end
        act = act_vec(); exp = model(4'd0, z, 1'b1); vectors++;
        if (act !== exp) begin errors++; $display("FAIL %s_refetch got=%b want=%b", name, act, exp); end
    endtask

    task automatic test_reset_mid_lw();
        logic [19:0] act;
        logic [19:0] exp;
        push_instr(6'b100011, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front(); act = act_vec(); vectors++;
            if (act !== exp) begin errors++; $display("FAIL midlw_s%0d got=%b want=%b", i, act, exp); end
            if (i < 3) begin @(posedge clk); #1; end
        end
        exp_q.delete();
        #2 rst_n = 1'b0; #1;
        act = act_vec(); exp = model(4'd0, 1'b0, 1'b0); vectors++;
        if (act !== exp) begin errors++; $display("FAIL midlw_async got=%b want=%b", act, exp); end
        @(posedge clk); #1;
        act = act_vec(); vectors++;
        if (act !== exp) begin errors++; $display("FAIL midlw_held got=%b want=%b", act, exp); end
        @(negedge clk); rst_n = 1'b1; #1;
        act = act_vec(); exp = model(4'd0, 1'b0, 1'b1); vectors++;
        if (act !== exp) begin errors++; $display("FAIL midlw_release got=%b want=%b", act, exp); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[8];
        logic [19:0] act;
        logic [19:0] exp;
        logic z;
        ops = '{6'b000000, 6'b101011, 6'b000100, 6'b100011,
                6'b001000, 6'b000010, 6'b111111, 6'b000100};
        foreach (ops[k]) begin
            z = 1'($urandom_range(0, 1));
            push_instr(ops[k], z);
            while (exp_q.size() > 0) begin
                exp = exp_q.pop_front(); act = act_vec(); vectors++;
                if (act !== exp) begin
                    errors++; $display("FAIL b2b_op%b got=%b want=%b", ops[k], act, exp);
                end
                @(posedge clk); #1;
            end
        end
        act = act_vec(); exp = model(4'd0, z, 1'b1); vectors++;
        if (act !== exp) begin errors++; $display("FAIL b2b_end got=%b want=%b", act, exp); end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_instr("lw", 6'b100011, 1'b0);
        test_instr("sw", 6'b101011, 1'b1);
        test_instr("rtype", 6'b000000, 1'b1);
        test_instr("addi", 6'b001000, 1'b0);
        test_instr("beq_taken", 6'b000100, 1'b1);
        test_instr("beq_not_taken", 6'b000100, 1'b0);
        test_instr("illegal", 6'b111111, 1'b1);
        test_instr("jump", 6'b000010, 1'b0);
        test_reset_mid_lw();
        test_instr("lw_after_reset", 6'b100011, 1'b1);
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
